pipeline_mem_arbiter: RTL and testbench

PIPELINE_MEM_ARBITER -- requirements
Module: pipeline_mem_arbiter

---
 rtl/pipeline_mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_pipeline_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one memory port.
// Only one memory transaction is ever outstanding. A waiting fetch is starved for at most D_STREAK_MAX data grants.
module pipeline_mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int D_STREAK_MAX = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [3:0]      d_be,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            stall_if,
    output logic            stall_mem
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX_C = 4'(D_STREAK_MAX);

    state_t            state_r;
    state_t            state_nxt_s;
    logic              owner_data_r;
    logic              we_r;
    logic [XLEN-1:0]   addr_r;
    logic [XLEN-1:0]   wdata_r;
    logic [3:0]        be_r;
    logic [3:0]        streak_r;

    logic              any_req_s;
    logic              pick_fetch_s;
    logic              grant_s;

    assign any_req_s    = if_req | d_req;
    // Data normally wins; a fetch that has waited out the streak limit takes the next slot.
    assign pick_fetch_s = if_req && (!d_req || (streak_r >= STREAK_MAX_C));
    assign grant_s      = (state_r == IDLE) && any_req_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = WAIT_GNT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_GNT: begin
                if (mem_gnt) begin
                    state_nxt_s = WAIT_RSP;
                end else begin
                    state_nxt_s = WAIT_GNT;
                end
            end
            WAIT_RSP: begin
                if (mem_rvalid) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_RSP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Latch the granted request and track the data-grant streak
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_data_r <= 1'b0;
            we_r         <= 1'b0;
            addr_r       <= '0;
            wdata_r      <= '0;
            be_r         <= 4'h0;
            streak_r     <= 4'h0;
        end else if (grant_s) begin
            if (pick_fetch_s) begin
                owner_data_r <= 1'b0;
                we_r         <= 1'b0;
                addr_r       <= if_addr;
                wdata_r      <= '0;
                be_r         <= 4'hF;
                streak_r     <= 4'h0;
            end else begin
                owner_data_r <= 1'b1;
                we_r         <= d_we;
                addr_r       <= d_addr;
                wdata_r      <= d_wdata;
                be_r         <= d_be;
                if (!if_req) begin
                    streak_r <= 4'h0;
                end else if (streak_r != 4'hF) begin
                    streak_r <= streak_r + 4'd1;
                end else begin
                    streak_r <= streak_r;
                end
            end
        end else begin
            owner_data_r <= owner_data_r;
            we_r         <= we_r;
            addr_r       <= addr_r;
            wdata_r      <= wdata_r;
            be_r         <= be_r;
            streak_r     <= streak_r;
        end
    end

    // Output decode; everything is forced low while reset is asserted
    always_comb begin
        if_gnt    = 1'b0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        d_gnt     = 1'b0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = 4'h0;
        stall_if  = 1'b0;
        stall_mem = 1'b0;
        if (rst_n) begin
            mem_addr  = addr_r;
            mem_wdata = wdata_r;
            mem_be    = be_r;
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        if_gnt = pick_fetch_s;
                        d_gnt  = !pick_fetch_s;
                    end else begin
                        if_gnt = 1'b0;
                        d_gnt  = 1'b0;
                    end
                end
                WAIT_GNT: begin
                    mem_req = 1'b1;
                    mem_we  = we_r;
                end
                WAIT_RSP: begin
                    if (mem_rvalid) begin
                        if_rvalid = !owner_data_r;
                        d_rvalid  = owner_data_r;
                        if_rdata  = owner_data_r ? '0 : mem_rdata;
                        d_rdata   = owner_data_r ? mem_rdata : '0;
                    end else begin
                        if_rvalid = 1'b0;
                        d_rvalid  = 1'b0;
                    end
                end
                default: begin
                    mem_req = 1'b0;
                end
            endcase
            stall_if  = if_req && !if_rvalid;
            stall_mem = d_req && !d_rvalid;
        end else begin
            mem_req = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Self-checking bench for pipeline_mem_arbiter: directed scenarios followed by randomized traffic
// checked against a transaction-level model of arbitration and a byte-addressed memory.
module tb_pipeline_mem_arbiter;

    localparam int XLEN = 32;
    localparam int DMAX = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_gnt, if_rvalid;
    logic [XLEN-1:0] if_rdata;
    logic            d_req, d_we;
    logic [XLEN-1:0] d_addr, d_wdata;
    logic [3:0]      d_be;
    logic            d_gnt, d_rvalid;
    logic [XLEN-1:0] d_rdata;
    logic            mem_req, mem_we;
    logic [XLEN-1:0] mem_addr, mem_wdata;
    logic [3:0]      mem_be;
    logic            mem_gnt, mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            stall_if, stall_mem;

    pipeline_mem_arbiter #(.XLEN(XLEN), .D_STREAK_MAX(DMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Requester model: what each side currently wants
    logic        if_pend = 1'b0;
    logic [31:0] if_a    = 32'h0;
    logic        d_pend  = 1'b0;
    logic        d_w     = 1'b0;
    logic [31:0] d_a     = 32'h0;
    logic [31:0] d_wd    = 32'h0;
    logic [3:0]  d_b     = 4'h0;
    int          streak_m = 0;
    logic        last_own = 1'b0;
    logic [31:0] mem_m [logic [31:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic mem_wr(input logic [31:0] a, input logic [31:0] v, input logic [3:0] be);
        logic [31:0] cur;
        cur = mem_rd(a);
        for (int i = 0; i < 4; i++) begin
            if (be[i]) cur[i*8 +: 8] = v[i*8 +: 8];
        end
        mem_m[a] = cur;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_reqs();
        if_req  = if_pend;
        if_addr = if_a;
        d_req   = d_pend;
        d_we    = d_w;
        d_addr  = d_a;
        d_wdata = d_wd;
        d_be    = d_b;
    endtask

    // One complete transaction starting in an idle cycle; ends positioned in the next idle cycle
    task automatic run_txn(input int gd, input int rd);
        logic        exp_d;
        logic [31:0] e_addr, e_wd, val;
        logic [3:0]  e_be;
        logic        e_we;
        drive_reqs();
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
        #2;
        exp_d = d_pend && !(if_pend && (streak_m >= DMAX));
        chk1("if_gnt", if_gnt, !exp_d);
        chk1("d_gnt", d_gnt, exp_d);
        chk1("stall_if_arb", stall_if, if_pend);
        chk1("stall_mem_arb", stall_mem, d_pend);
        chk1("mem_req_idle", mem_req, 1'b0);
        last_own = d_gnt;
        e_addr = exp_d ? d_a : if_a;
        e_we   = exp_d ? d_w : 1'b0;
        e_wd   = d_wd;
        e_be   = d_b;
        if (!exp_d) streak_m = 0;
        else if (if_pend) streak_m = streak_m + 1;
        else streak_m = 0;
        for (int k = 0; k <= gd; k++) begin
            tick();
            if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
            d_we = 1'($urandom);
            mem_gnt = (k == gd); mem_rdata = $urandom; mem_rvalid = 1'($urandom);
            #2;
            chk1("mem_req_wait", mem_req, 1'b1);
            chk("mem_addr", mem_addr, e_addr);
            chk1("mem_we", mem_we, e_we);
            if (exp_d) begin
                chk("mem_wdata", mem_wdata, e_wd);
                chk("mem_be", {28'd0, mem_be}, {28'd0, e_be});
            end
            chk1("no_gnt_wait", if_gnt | d_gnt, 1'b0);
            chk1("no_rvalid_wait", if_rvalid | d_rvalid, 1'b0);
            chk1("stall_if_wait", stall_if, if_pend);
            chk1("stall_mem_wait", stall_mem, d_pend);
        end
        val = (exp_d && e_we) ? $urandom : mem_rd(e_addr);
        for (int k = 0; k <= rd; k++) begin
            tick();
            drive_reqs();
            mem_gnt = 1'b0; mem_rvalid = (k == rd);
            mem_rdata = (k == rd) ? val : $urandom;
            #2;
            chk1("mem_req_rsp", mem_req, 1'b0);
            chk1("mem_we_rsp", mem_we, 1'b0);
            if (k == rd) begin
                chk1("if_rvalid", if_rvalid, !exp_d);
                chk1("d_rvalid", d_rvalid, exp_d);
                if (exp_d) begin
                    chk("if_rdata_idle", if_rdata, 32'h0);
                    if (!e_we) chk("d_rdata", d_rdata, val);
                end else begin
                    chk("if_rdata", if_rdata, val);
                    chk("d_rdata_idle", d_rdata, 32'h0);
                end
                chk1("stall_if_rsp", stall_if, if_pend && exp_d);
                chk1("stall_mem_rsp", stall_mem, d_pend && !exp_d);
            end else begin
                chk1("no_rvalid_rsp", if_rvalid | d_rvalid, 1'b0);
                chk("rdata_zero", if_rdata | d_rdata, 32'h0);
            end
        end
        if (exp_d && e_we) mem_wr(e_addr, e_wd, e_be);
        if (exp_d) d_pend = 1'b0;
        else if_pend = 1'b0;
        tick();
    endtask

    task automatic idle_cycle();
        drive_reqs();
        mem_gnt = 1'($urandom); mem_rvalid = 1'($urandom); mem_rdata = $urandom;
        #2;
        chk1("idle_no_gnt", if_gnt | d_gnt, 1'b0);
        chk1("idle_no_rvalid", if_rvalid | d_rvalid, 1'b0);
        chk1("idle_mem_req", mem_req, 1'b0);
        tick();
    endtask

    function automatic logic any_out();
        return |{if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_req, mem_we,
                 mem_addr, mem_wdata, mem_be, stall_if, stall_mem};
    endfunction

    initial begin
        logic [4:0] seq;
        // Reset with every input active: outputs must all be low
        rst_n = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; if_addr = 32'h44; d_addr = 32'h88;
        d_wdata = 32'h1234; d_be = 4'hF; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        #12;
        chk1("reset_outputs", any_out(), 1'b0);
        tick();
        rst_n = 1'b1;

        // Fetch-only, minimum latency, first edge after reset release
        if_pend = 1'b1; if_a = 32'h40; mem_m[32'h40] = 32'h0050_0093;
        run_txn(0, 0);
        chk1("fetch_only_owner", last_own, 1'b0);

        // Simultaneous requests: data first, fetch at next idle
        if_pend = 1'b1; if_a = 32'h44; d_pend = 1'b1; d_w = 1'b0; d_a = 32'h200; d_b = 4'hF;
        run_txn(0, 0);
        chk1("simul_first_data", last_own, 1'b1);
        run_txn(1, 1);
        chk1("simul_then_fetch", last_own, 1'b0);

        // Starvation bound with continuous data traffic
        for (int i = 0; i < 5; i++) begin
            if (!if_pend) begin if_pend = 1'b1; if_a = 32'h48 + 32'(i) * 32'd4; end
            d_pend = 1'b1; d_w = 1'b0; d_a = 32'h204 + 32'(i) * 32'd4;
            run_txn(0, 0);
            seq[i] = last_own;
        end
        chk("starve_seq", {27'd0, seq}, {27'd0, 5'b10111});
        if_pend = 1'b0;
        idle_cycle();

        // Write under 4 cycles of back-pressure, then read it back
        d_pend = 1'b1; d_w = 1'b1; d_a = 32'h100; d_wd = 32'hDEAD_BEEF; d_b = 4'hF;
        run_txn(4, 1);
        chk1("write_owner", last_own, 1'b1);
        d_pend = 1'b1; d_w = 1'b0;
        run_txn(0, 0);
        chk("write_readback", mem_rd(32'h100), 32'hDEAD_BEEF);

        // Reset while waiting for the response, then a stray response
        if_pend = 1'b1; if_a = 32'h80;
        drive_reqs(); mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #2;
        chk1("rst_case_gnt", if_gnt, 1'b1);
        tick();
        mem_gnt = 1'b1;
        #2;
        chk1("rst_case_mem_req", mem_req, 1'b1);
        tick();
        mem_gnt = 1'b0; d_req = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk1("rst_mid_outputs", any_out(), 1'b0);
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        #2;
        chk1("rst_mid_outputs_rvalid", any_out(), 1'b0);
        tick();
        rst_n = 1'b1; if_pend = 1'b0; d_pend = 1'b0; streak_m = 0;
        if_req = 1'b0; d_req = 1'b0; mem_rvalid = 1'b1;
        #2;
        chk1("stray_if_rvalid", if_rvalid, 1'b0);
        chk1("stray_d_rvalid", d_rvalid, 1'b0);
        chk("stray_rdata", if_rdata | d_rdata, 32'h0);
        tick();
        mem_rvalid = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            if (!if_pend && ($urandom_range(0, 2) != 0)) begin
                if_pend = 1'b1; if_a = 32'h200 + 32'($urandom_range(0, 7)) * 32'd4;
            end
            if (!d_pend && ($urandom_range(0, 2) != 0)) begin
                d_pend = 1'b1; d_w = 1'($urandom); d_a = 32'h200 + 32'($urandom_range(0, 7)) * 32'd4;
                d_wd = $urandom; d_b = 4'($urandom);
            end
            if (!if_pend && !d_pend) idle_cycle();
            else run_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
